signed_mult_bcd_core: RTL and testbench

//   Sequential 8x8 signed multiplier with binary-to-BCD conversion. Feeds the seven-segment scroller stage.

---
 rtl/signed_mult_bcd_core_if.sv | 31 +++
 rtl/signed_mult_bcd_core.sv | 184 ++++++++++++++++++
 tb/tb_signed_mult_bcd_core.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/signed_mult_bcd_core_if.sv
// ============================================================================
//  Module      : signed_mult_bcd_core_if
//  Description : Operand/result bundle between the operand registers and the
//                signed multiplier / BCD converter core.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface signed_mult_bcd_core_if;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [19:0] product;
    logic        sign;
    logic        busy;
    logic        done;

    // Requester side: drives operands and start, observes the result
    modport master (
        output start, multiplicand, multiplier,
        input  product, sign, busy, done
    );

    // Core side
    modport slave (
        input  start, multiplicand, multiplier,
        output product, sign, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/signed_mult_bcd_core.sv
// ============================================================================
//  Module      : signed_mult_bcd_core
//  Description : Sequential 8x8 signed multiplier (shift-add on magnitudes)
//                followed by a 15-step double-dabble conversion to five BCD
//                digits. Result is a 20-bit BCD magnitude plus a sign bit.
//                Optional feature macro: MULT_ZERO_BYPASS_EN -- a zero
//                operand skips MULT/CONV and publishes zero one cycle later.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module signed_mult_bcd_core #(
    parameter int START_EDGE = 1   // 1: rising-edge start, 0: level start
) (
    input  wire logic               clk,
    input  wire logic               reset,
    signed_mult_bcd_core_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_CONV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [3:0]  cnt_q,        cnt_d;        // MULT: bit index, CONV: shifts done
    logic [7:0]  mag_a_q,      mag_a_d;
    logic [7:0]  mag_b_q,      mag_b_d;
    logic [15:0] acc_q,        acc_d;
    logic [19:0] scratch_q,    scratch_d;
    logic        sign_next_q,  sign_next_d;
    logic        start_prev_q, start_prev_d;
    logic [19:0] product_q,    product_d;
    logic        sign_q,       sign_d;
    logic        busy_q,       busy_d;
    logic        done_q,       done_d;

    logic        start_accept;
    logic [15:0] partial;
    logic [19:0] dabble_adj;
    logic [3:0]  conv_bit_idx;
    logic        zero_operand;

    assign bus.product = product_q;
    assign bus.sign    = sign_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    // Start qualification: edge detect against the history register, or level
    always_comb begin
        if (START_EDGE != 0) begin
            start_accept = (state_q == S_IDLE) && bus.start && !start_prev_q;
        end else begin
            start_accept = (state_q == S_IDLE) && bus.start;
        end
    end

    // Datapath helpers: shifted multiplicand, +3 nibble correction, next magnitude bit
    always_comb begin
        partial      = {8'd0, mag_a_q} << cnt_q[2:0];
        conv_bit_idx = 4'd14 - cnt_q;           // MSB of the 15-bit magnitude first
        zero_operand = (bus.multiplicand == 8'd0) || (bus.multiplier == 8'd0);
        dabble_adj   = scratch_q;
        for (int k = 0; k < 5; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                dabble_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Next-state and next-output computation for the whole sequencer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mag_a_d      = mag_a_q;
        mag_b_d      = mag_b_q;
        acc_d        = acc_q;
        scratch_d    = scratch_q;
        sign_next_d  = sign_next_q;
        start_prev_d = bus.start;               // history tracks start in every state
        product_d    = product_q;
        sign_d       = sign_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_accept) begin
                    // Two's-complement negate in 8 bits: |-128| wraps to 8'h80 = 128 unsigned
                    mag_a_d     = bus.multiplicand[7] ? (8'd0 - bus.multiplicand) : bus.multiplicand;
                    mag_b_d     = bus.multiplier[7]   ? (8'd0 - bus.multiplier)   : bus.multiplier;
                    sign_next_d = bus.multiplicand[7] ^ bus.multiplier[7];
                    acc_d       = 16'd0;
                    scratch_d   = 20'd0;
                    cnt_d       = 4'd0;
                    state_d     = S_MULT;
                    busy_d      = 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
                    // Park in CONV with the shift count exhausted: the next
                    // edge publishes a zero result without raising busy.
                    if (zero_operand) begin
                        sign_next_d = 1'b0;
                        cnt_d       = 4'd15;
                        state_d     = S_CONV;
                        busy_d      = 1'b0;
                    end
`endif
                end
            end

            S_MULT: begin
                if (mag_b_q[cnt_q[2:0]]) begin
                    acc_d = acc_q + partial;
                end
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    state_d = S_CONV;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_CONV: begin
                if (cnt_q == 4'd15) begin
                    // All 15 magnitude bits shifted in: publish
                    product_d = scratch_q;
                    sign_d    = sign_next_q & (|acc_q);
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    scratch_d = {dabble_adj[18:0], acc_q[conv_bit_idx]};
                    cnt_d     = cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State register; asynchronous reset aborts any operation without publishing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            mag_a_q      <= 8'd0;
            mag_b_q      <= 8'd0;
            acc_q        <= 16'd0;
            scratch_q    <= 20'd0;
            sign_next_q  <= 1'b0;
            start_prev_q <= 1'b0;
            product_q    <= 20'd0;
            sign_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mag_a_q      <= mag_a_d;
            mag_b_q      <= mag_b_d;
            acc_q        <= acc_d;
            scratch_q    <= scratch_d;
            sign_next_q  <= sign_next_d;
            start_prev_q <= start_prev_d;
            product_q    <= product_d;
            sign_q       <= sign_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // zero_operand only feeds the optional bypass path
    logic unused_ok;
    assign unused_ok = zero_operand;

endmodule

`default_nettype wire

// File: tb/tb_signed_mult_bcd_core.sv
// ============================================================================
//  Module      : tb_signed_mult_bcd_core
//  Description : Directed testbench for signed_mult_bcd_core (START_EDGE=1).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_signed_mult_bcd_core;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    signed_mult_bcd_core_if bus ();

    signed_mult_bcd_core #(.START_EDGE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULT_ZERO_BYPASS_EN
    localparam int ZERO_LAT  = 1;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_LAT  = 24;
    localparam int ZERO_BUSY = 24;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start high; returns just after the accepting edge E0
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input bit hold);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen, and busy-high cycles from E0 on
    task automatic wait_done(output int n, output int busy_n);
        n      = 0;
        busy_n = bus.busy ? 1 : 0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (bus.done) break;
            if (bus.busy) busy_n++;
        end
    endtask

    task automatic count_dones(input int cycles, output int d);
        d = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.done) d++;
        end
    endtask

    task automatic op_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [19:0] exp_p, input logic exp_s,
                            input int exp_lat, input int exp_busy);
        int n, bn;
        start_op(a, b, 1'b0);
        wait_done(n, bn);
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " busy cycles"}, bn, exp_busy);
        chk({tag, " product"}, {12'd0, bus.product}, {12'd0, exp_p});
        chk({tag, " sign"}, {31'd0, bus.sign}, {31'd0, exp_s});
        chk({tag, " busy at done"}, {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, {31'd0, bus.done}, 32'd0);
        chk({tag, " product held"}, {12'd0, bus.product}, {12'd0, exp_p});
    endtask

    initial begin
        int n, bn, d;
        compared   = 0;
        mismatched = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = 8'd0;
        bus.multiplier   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset product", {12'd0, bus.product}, 32'd0);
        chk("reset sign",    {31'd0, bus.sign},    32'd0);
        chk("reset busy",    {31'd0, bus.busy},    32'd0);
        chk("reset done",    {31'd0, bus.done},    32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        op_check("5x3",       8'd5,   8'd3,   20'h00015, 1'b0, 24, 24);
        op_check("-7x12",     8'hF9,  8'd12,  20'h00084, 1'b1, 24, 24);
        op_check("-128x-128", 8'h80,  8'h80,  20'h16384, 1'b0, 24, 24);
        op_check("127x-128",  8'd127, 8'h80,  20'h16256, 1'b1, 24, 24);
        op_check("-5x0",      8'hFB,  8'd0,   20'h00000, 1'b0, ZERO_LAT, ZERO_BUSY);
        op_check("-1x-1",     8'hFF,  8'hFF,  20'h00001, 1'b0, 24, 24);

        // Start pulse with different operands 10 cycles into a run is ignored
        start_op(8'd9, 8'd9, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        bus.multiplicand = 8'd2;
        bus.multiplier   = 8'd2;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(n, bn);
        chk("ignored start latency", n + 10, 24);
        chk("ignored start product", {12'd0, bus.product}, 32'h00081);
        count_dones(40, d);
        chk("ignored start extra dones", d, 0);

        // Held start with edge detection yields exactly one result
        start_op(8'd3, 8'hFC, 1'b1);
        wait_done(n, bn);
        chk("held start latency", n, 24);
        chk("held start product", {12'd0, bus.product}, 32'h00012);
        chk("held start sign", {31'd0, bus.sign}, 32'd1);
        count_dones(40, d);
        chk("held start extra dones", d, 0);
        bus.start = 1'b0;
        @(posedge clk); #1;

        // Reset 12 cycles into a run clears outputs at once and publishes nothing
        start_op(8'd100, 8'd100, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort product", {12'd0, bus.product}, 32'd0);
        chk("abort sign",    {31'd0, bus.sign},    32'd0);
        chk("abort busy",    {31'd0, bus.busy},    32'd0);
        chk("abort done",    {31'd0, bus.done},    32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        count_dones(30, d);
        chk("abort no done", d, 0);
        op_check("-100x100", 8'h9C, 8'd100, 20'h10000, 1'b1, 24, 24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
